// File: rtl/ex_stage_if.sv
// Execute-stage bundle: decode/execute latch fields in, result/branch/CCR status out.
interface ex_stage_if #(
  parameter int DATA_W = 8
);
  logic              ld;
  logic [DATA_W-1:0] R_ra;
  logic [DATA_W-1:0] R_rb;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] in_port;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        has_hazard;
  logic [3:0]        ALU;
  logic [4:0]        Flags;
  logic [2:0]        BU;
  logic              SE2;
  logic [1:0]        SE3;
  logic              Hlt;
  logic              intr_save;
  logic [DATA_W-1:0] result;
  logic [3:0]        ccr;
  logic              branch_taken;
  logic              halted;

  modport master (
    output ld, R_ra, R_rb, imm, in_port, fwd_data, has_hazard,
    output ALU, Flags, BU, SE2, SE3, Hlt, intr_save,
    input  result, ccr, branch_taken, halted
  );

  modport slave (
    input  ld, R_ra, R_rb, imm, in_port, fwd_data, has_hazard,
    input  ALU, Flags, BU, SE2, SE3, Hlt, intr_save,
    output result, ccr, branch_taken, halted
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, condition-code register with interrupt
// shadow, branch resolution against registered flags, and sticky halt.
module ex_stage #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  ex_stage_if.slave    bus
);
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] ALU_MOV  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_NEG  = 4'd6;
  localparam logic [3:0] ALU_INC  = 4'd7;
  localparam logic [3:0] ALU_DEC  = 4'd8;
  localparam logic [3:0] ALU_RLC  = 4'd9;
  localparam logic [3:0] ALU_RRC  = 4'd10;
  localparam logic [3:0] ALU_SETC = 4'd11;
  localparam logic [3:0] ALU_CLRC = 4'd12;

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_pre_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_out_s;
  logic [DATA_W-1:0] one_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   diff_s;
  logic              c_new_s;
  logic              v_new_s;
  logic [3:0]        flag_val_s;
  logic [3:0]        ccr_next_s;
  logic [DATA_W-1:0] result_s;
  logic              branch_s;
  logic              adv_s;
  logic [3:0]        ccr_r;
  logic [3:0]        shadow_r;
  logic              halted_r;

  // Immediate sits after the forwarding mux so forwarding never overrides it.
  assign op_a_s     = bus.has_hazard[0] ? bus.fwd_data : bus.R_ra;
  assign op_b_pre_s = bus.has_hazard[1] ? bus.fwd_data : bus.R_rb;
  assign op_b_s     = bus.SE2 ? bus.imm : op_b_pre_s;
  assign one_s      = {{(DATA_W-1){1'b0}}, 1'b1};
  assign sum_s      = {1'b0, op_a_s} + {1'b0, op_b_s};
  assign diff_s     = {1'b0, op_a_s} - {1'b0, op_b_s};
  assign adv_s      = bus.ld & ~halted_r;

  // ALU datapath; C and V default to their current CCR value.
  always_comb begin
    alu_out_s = op_b_s;
    c_new_s   = ccr_r[2];
    v_new_s   = ccr_r[3];
    case (bus.ALU)
      ALU_MOV: alu_out_s = op_b_s;
      ALU_ADD: begin
        alu_out_s = sum_s[MSB:0];
        c_new_s   = sum_s[DATA_W];
        v_new_s   = (op_a_s[MSB] == op_b_s[MSB]) && (sum_s[MSB] != op_a_s[MSB]);
      end
      ALU_SUB: begin
        alu_out_s = diff_s[MSB:0];
        c_new_s   = diff_s[DATA_W];
        v_new_s   = (op_a_s[MSB] != op_b_s[MSB]) && (diff_s[MSB] != op_a_s[MSB]);
      end
      ALU_AND: alu_out_s = op_a_s & op_b_s;
      ALU_OR:  alu_out_s = op_a_s | op_b_s;
      ALU_NOT: alu_out_s = ~op_b_s;
      ALU_NEG: begin
        alu_out_s = {DATA_W{1'b0}} - op_b_s;
        c_new_s   = |op_b_s;
      end
      ALU_INC: begin
        alu_out_s = op_b_s + one_s;
        c_new_s   = &op_b_s;
      end
      ALU_DEC: begin
        alu_out_s = op_b_s - one_s;
        c_new_s   = ~|op_b_s;
      end
      ALU_RLC: begin
        alu_out_s = {op_b_s[MSB-1:0], ccr_r[2]};
        c_new_s   = op_b_s[MSB];
      end
      ALU_RRC: begin
        alu_out_s = {ccr_r[2], op_b_s[MSB:1]};
        c_new_s   = op_b_s[0];
      end
      ALU_SETC: c_new_s = 1'b1;
      ALU_CLRC: c_new_s = 1'b0;
      default:  alu_out_s = op_b_s;
    endcase
  end

  assign flag_val_s = {v_new_s, c_new_s, alu_out_s[MSB], ~|alu_out_s};

  // Next CCR: shadow restore overrides the per-bit write enables.
  always_comb begin
    if (bus.Flags[4]) begin
      ccr_next_s = shadow_r;
    end else begin
      ccr_next_s = (bus.Flags[3:0] & flag_val_s) | (~bus.Flags[3:0] & ccr_r);
    end
  end

  // Result select.
  always_comb begin
    case (bus.SE3)
      2'd0:    result_s = alu_out_s;
      2'd1:    result_s = op_a_s;
      2'd2:    result_s = op_b_s;
      2'd3:    result_s = bus.in_port;
      default: result_s = alu_out_s;
    endcase
  end

  // Branch resolution uses registered flags, except LOOP which tests the ALU output.
  always_comb begin
    if (!bus.ld || halted_r) begin
      branch_s = 1'b0;
    end else begin
      case (bus.BU)
        3'd0:    branch_s = 1'b0;
        3'd1:    branch_s = ccr_r[0];
        3'd2:    branch_s = ccr_r[1];
        3'd3:    branch_s = ccr_r[2];
        3'd4:    branch_s = ccr_r[3];
        3'd5:    branch_s = 1'b1;
        3'd6:    branch_s = |alu_out_s;
        3'd7:    branch_s = 1'b0;
        default: branch_s = 1'b0;
      endcase
    end
  end

  // Architectural state; shadow captures the pre-update CCR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccr_r    <= 4'b0000;
      shadow_r <= 4'b0000;
      halted_r <= 1'b0;
    end else begin
      if (adv_s) begin
        ccr_r <= ccr_next_s;
        if (bus.intr_save) begin
          shadow_r <= ccr_r;
        end
      end
      if (bus.ld && bus.Hlt) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign bus.result       = result_s;
  assign bus.branch_taken = branch_s;
  assign bus.ccr          = ccr_r;
  assign bus.halted       = halted_r;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed scenarios then randomized traffic
// checked against an arithmetic reference model.
module tb_ex_stage;
  logic clk = 1'b1;
  logic reset;

  always #5 clk = ~clk;

  ex_stage_if #(.DATA_W(8)) bus();
  ex_stage #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [7:0] res;
    logic       br;
    logic [3:0] ccr;
    logic       hlt;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_ccr, m_shadow, nx_ccr;
  logic       m_halted;

  function automatic int sg(int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Model: expected outputs for the current inputs, plus the CCR the next edge should load.
  task automatic drive_push();
    int a, b, out, s;
    logic c, v;
    logic [7:0] o8;
    logic [3:0] fv;
    exp_t e;
    a = int'(bus.has_hazard[0] ? bus.fwd_data : bus.R_ra);
    b = bus.SE2 ? int'(bus.imm) : int'(bus.has_hazard[1] ? bus.fwd_data : bus.R_rb);
    c = m_ccr[2];
    v = m_ccr[3];
    case (int'(bus.ALU))
      1: begin out = a + b; c = (out > 255); s = sg(a) + sg(b); v = (s > 127) || (s < -128); end
      2: begin out = a - b; c = (a < b); s = sg(a) - sg(b); v = (s > 127) || (s < -128); end
      3: out = a & b;
      4: out = a | b;
      5: out = 255 - b;
      6: begin out = -b; c = (b != 0); end
      7: begin out = b + 1; c = (b == 255); end
      8: begin out = b - 1; c = (b == 0); end
      9: begin out = b * 2 + (m_ccr[2] ? 1 : 0); c = (b >= 128); end
      10: begin out = b / 2 + (m_ccr[2] ? 128 : 0); c = (b % 2 == 1); end
      11: begin out = b; c = 1'b1; end
      12: begin out = b; c = 1'b0; end
      default: out = b;
    endcase
    o8 = 8'(out);
    fv = {v, c, (o8 >= 8'h80), (o8 == 8'h00)};
    for (int i = 0; i < 4; i++) nx_ccr[i] = bus.Flags[i] ? fv[i] : m_ccr[i];
    if (bus.Flags[4]) nx_ccr = m_shadow;
    case (int'(bus.SE3))
      0: e.res = o8;
      1: e.res = 8'(a);
      2: e.res = 8'(b);
      default: e.res = bus.in_port;
    endcase
    if (!bus.ld || m_halted) e.br = 1'b0;
    else begin
      case (int'(bus.BU))
        1, 2, 3, 4: e.br = m_ccr[int'(bus.BU) - 1];
        5: e.br = 1'b1;
        6: e.br = (o8 != 8'h00);
        default: e.br = 1'b0;
      endcase
    end
    e.ccr = m_ccr;
    e.hlt = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic commit();
    if (reset) begin
      if (bus.ld && !m_halted) begin
        if (bus.intr_save) m_shadow = m_ccr;
        m_ccr = nx_ccr;
      end
      if (bus.ld && bus.Hlt) m_halted = 1'b1;
    end
  endtask

  task automatic cycle();
    drive_push();
    @(posedge clk);
    commit();
    #1;
  endtask

  // Reset pulled low between edges; the scoreboard entry checks the cleared state while it is still low.
  task automatic reset_pulse();
    reset = 1'b0;
    m_ccr = 4'b0000; m_shadow = 4'b0000; m_halted = 1'b0;
    drive_push();
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic op(input logic [3:0] alu, input logic [7:0] ra, input logic [7:0] rb,
                    input logic [4:0] flags, input logic [2:0] bu);
    bus.ld = 1'b1; bus.R_ra = ra; bus.R_rb = rb; bus.imm = 8'h00; bus.in_port = 8'h5A;
    bus.fwd_data = 8'h00; bus.has_hazard = 2'b00; bus.ALU = alu; bus.Flags = flags;
    bus.BU = bu; bus.SE2 = 1'b0; bus.SE3 = 2'd0; bus.Hlt = 1'b0; bus.intr_save = 1'b0;
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", bus.result, e.res);
        chk("branch_taken", {7'd0, bus.branch_taken}, {7'd0, e.br});
        chk("ccr", {4'd0, bus.ccr}, {4'd0, e.ccr});
        chk("halted", {7'd0, bus.halted}, {7'd0, e.hlt});
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    m_ccr = 4'b0000; m_shadow = 4'b0000; m_halted = 1'b0; nx_ccr = 4'b0000;
    op(4'd1, 8'h7F, 8'h01, 5'b01111, 3'd0);
    #1 reset = 1'b0;
    cycle();                                  // reset state visible, result=80
    reset = 1'b1;
    cycle();                                  // ADD commits: V=1 N=1
    op(4'd2, 8'h05, 8'h05, 5'b01111, 3'd1); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd1); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd3); cycle();
    // Forwarding, then immediate bypassing the forwarding path
    op(4'd3, 8'h00, 8'h00, 5'b00000, 3'd0);
    bus.has_hazard = 2'b11; bus.fwd_data = 8'h0F; cycle();
    bus.SE2 = 1'b1; bus.imm = 8'hF0; cycle();
    // Shadow save and restore
    op(4'd11, 8'h00, 8'h00, 5'b00101, 3'd0); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd0); bus.intr_save = 1'b1; cycle();
    op(4'd12, 8'h00, 8'h01, 5'b00101, 3'd0); cycle();
    op(4'd11, 8'h00, 8'h01, 5'b00100, 3'd0); cycle();
    op(4'd12, 8'h00, 8'h01, 5'b00101, 3'd0); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b10000, 3'd0); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd1); cycle();
    // Stalled halt must not take effect, then a real halt freezes state
    op(4'd1, 8'h01, 8'h01, 5'b01111, 3'd5); bus.ld = 1'b0; bus.Hlt = 1'b1; cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd0); bus.Hlt = 1'b1; cycle();
    op(4'd1, 8'h7F, 8'h7F, 5'b01111, 3'd5); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b10000, 3'd5); bus.intr_save = 1'b1; cycle();
    // Build ccr=1111 and halt, then reset mid-cycle
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd0); reset_pulse();
    op(4'd2, 8'h05, 8'h05, 5'b00001, 3'd0); cycle();
    op(4'd0, 8'h00, 8'h80, 5'b00010, 3'd0); cycle();
    op(4'd11, 8'h00, 8'h00, 5'b00100, 3'd0); cycle();
    op(4'd1, 8'h7F, 8'h01, 5'b01000, 3'd0); cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd0); bus.Hlt = 1'b1; cycle();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd2); cycle();
    op(4'd9, 8'h00, 8'h81, 5'b00100, 3'd0); reset_pulse();
    op(4'd0, 8'h00, 8'h00, 5'b00000, 3'd3); cycle();
    // Randomized traffic with periodic asynchronous resets to leave the halt state
    for (int i = 0; i < 400; i++) begin
      bus.ld         = ($urandom_range(7) != 0);
      bus.R_ra       = 8'($urandom);
      bus.R_rb       = 8'($urandom);
      bus.imm        = 8'($urandom);
      bus.in_port    = 8'($urandom);
      bus.fwd_data   = 8'($urandom);
      bus.has_hazard = 2'($urandom_range(3));
      bus.ALU        = 4'($urandom_range(15));
      bus.Flags      = {($urandom_range(7) == 0), 4'($urandom_range(15))};
      bus.BU         = 3'($urandom_range(7));
      bus.SE2        = 1'($urandom_range(1));
      bus.SE3        = 2'($urandom_range(3));
      bus.Hlt        = ($urandom_range(59) == 0);
      bus.intr_save  = ($urandom_range(3) == 0);
      if (i % 50 == 49) reset_pulse();
      else cycle();
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
